// File: rtl/fwd_hazard_unit.sv
// Operand forwarding (EX > MEM > WB > register file) with load-use stall FSM.
// Optional cumulative stall counter enabled by defining FWD_PERF_CNT_EN.
module fwd_operand_sel #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] rfData,
  input  logic              exFwd,
  input  logic [REG_AW-1:0] exRw,
  input  logic [DATA_W-1:0] exResult,
  input  logic              memWe,
  input  logic [REG_AW-1:0] memRw,
  input  logic [DATA_W-1:0] memResult,
  input  logic              wbWe,
  input  logic [REG_AW-1:0] wbRw,
  input  logic [DATA_W-1:0] wbResult,
  output logic [DATA_W-1:0] fwd
);
  // r0 is hardwired: never forwarded, whatever the later stages claim.
  always_comb begin
    fwd = rfData;
    if (src != '0) begin
      if (exFwd && exRw == src)        fwd = exResult;
      else if (memWe && memRw == src)  fwd = memResult;
      else if (wbWe && wbRw == src)    fwd = wbResult;
    end
  end
endmodule

module fwd_hazard_unit #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  input  logic [REG_AW-1:0] ex_rw,
  input  logic              ex_we,
  input  logic              ex_load,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_AW-1:0] mem_rw,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [REG_AW-1:0] wb_rw,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] busAF,
  output logic [DATA_W-1:0] busBF,
  output logic              stall,
  output logic              bubble,
  output logic [31:0]       stall_cnt
);
  localparam int NUM_OPS = 2;
  localparam logic [1:0] CNT_INIT = 2'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);

  typedef enum logic {IDLE, STALL} state_t;

  state_t                              state;
  logic [1:0]                          cnt;
  logic                                hazard;
  logic [NUM_OPS-1:0][REG_AW-1:0]      srcV;
  logic [NUM_OPS-1:0][DATA_W-1:0]      rfV;
  logic [NUM_OPS-1:0][DATA_W-1:0]      fwdV;

  assign srcV = {id_rt, id_rs};
  assign rfV  = {busB, busA};

  // A load in EX has no data yet, so it is never a forwarding source.
  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : gOp
      fwd_operand_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) uSel (
        .src(srcV[g]), .rfData(rfV[g]),
        .exFwd(ex_we & ~ex_load), .exRw(ex_rw), .exResult(ex_result),
        .memWe(mem_we), .memRw(mem_rw), .memResult(mem_result),
        .wbWe(wb_we), .wbRw(wb_rw), .wbResult(wb_result),
        .fwd(fwdV[g])
      );
    end
  endgenerate

  assign busAF = fwdV[0];
  assign busBF = fwdV[1];

  assign hazard = id_valid & ex_we & ex_load & (ex_rw != '0) &
                  ((ex_rw == id_rs) | (ex_rw == id_rt));

  // First stall cycle is the hazard cycle itself; STALL covers the rest.
  assign stall  = (state == STALL) | hazard;
  assign bubble = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (hazard && LOAD_LAT > 1) begin
          state <= STALL;
          cnt   <= CNT_INIT;
        end
        STALL: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stallCnt;
  always_ff @(posedge clk) begin
    if (reset)                             stallCnt <= '0;
    else if (stall && stallCnt != '1)      stallCnt <= stallCnt + 32'd1;
  end
  assign stall_cnt = stallCnt;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized + directed bench for fwd_hazard_unit: two instances (LOAD_LAT 3 and 1)
// share stimulus and are checked against a remaining-cycles reference model.
module tb_fwd_hazard_unit;
  logic        clk = 0, reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, ex_rw, mem_rw, wb_rw;
  logic [31:0] busA, busB, ex_result, mem_result, wb_result;
  logic        ex_we, ex_load, mem_we, wb_we;
  logic [31:0] busAF[2], busBF[2], stall_cnt[2];
  logic        stall[2], bubble[2];

  int          nVec = 0, nErr = 0;
  int          lat[2] = '{3, 1};
  int          left[2];
  logic [31:0] cnt[2];

  always #5 clk = ~clk;

  fwd_hazard_unit #(.LOAD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .busA(busA), .busB(busB), .ex_rw(ex_rw), .ex_we(ex_we), .ex_load(ex_load),
    .ex_result(ex_result), .mem_rw(mem_rw), .mem_we(mem_we), .mem_result(mem_result),
    .wb_rw(wb_rw), .wb_we(wb_we), .wb_result(wb_result),
    .busAF(busAF[0]), .busBF(busBF[0]), .stall(stall[0]), .bubble(bubble[0]),
    .stall_cnt(stall_cnt[0]));

  fwd_hazard_unit #(.LOAD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .busA(busA), .busB(busB), .ex_rw(ex_rw), .ex_we(ex_we), .ex_load(ex_load),
    .ex_result(ex_result), .mem_rw(mem_rw), .mem_we(mem_we), .mem_result(mem_result),
    .wb_rw(wb_rw), .wb_we(wb_we), .wb_result(wb_result),
    .busAF(busAF[1]), .busBF(busBF[1]), .stall(stall[1]), .bubble(bubble[1]),
    .stall_cnt(stall_cnt[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: newest producing stage wins; loads in EX produce nothing yet.
  function automatic logic [31:0] fwdRef(input logic [4:0] src, input logic [31:0] rf);
    if (src == 0) return rf;
    if (ex_we && !ex_load && ex_rw == src) return ex_result;
    if (mem_we && mem_rw == src) return mem_result;
    if (wb_we && wb_rw == src) return wb_result;
    return rf;
  endfunction

  function automatic bit hazRef();
    return id_valid && ex_we && ex_load && ex_rw != 0 && (ex_rw == id_rs || ex_rw == id_rt);
  endfunction

  // Stall while a previous event still owes cycles; otherwise a new hazard stalls now.
  function automatic bit stallRef(input int d);
    return (left[d] > 0) ? 1'b1 : hazRef();
  endfunction

  function automatic logic [31:0] cntRef(input int d);
`ifdef FWD_PERF_CNT_EN
    return cnt[d];
`else
    return 32'd0;
`endif
  endfunction

  task automatic settle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busAF[%0d]", d), busAF[d], fwdRef(id_rs, busA));
      chk($sformatf("busBF[%0d]", d), busBF[d], fwdRef(id_rt, busB));
      chk($sformatf("stall[%0d]", d), 32'(stall[d]), 32'(stallRef(d)));
      chk($sformatf("bubble[%0d]", d), 32'(bubble[d]), 32'(stallRef(d)));
      chk($sformatf("stall_cnt[%0d]", d), stall_cnt[d], cntRef(d));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        left[d] = 0;
        cnt[d]  = 0;
      end else begin
        if (stallRef(d) && cnt[d] != 32'hFFFF_FFFF) cnt[d]++;
        if (left[d] > 0) left[d]--;
        else if (hazRef()) left[d] = lat[d] - 1;
      end
    end
    #1;
  endtask

  task automatic quiet();
    id_valid = 0; id_rs = 0; id_rt = 0; busA = 32'h1111; busB = 32'h2222;
    ex_rw = 0; ex_we = 0; ex_load = 0; ex_result = 0;
    mem_rw = 0; mem_we = 0; mem_result = 0; wb_rw = 0; wb_we = 0; wb_result = 0;
  endtask

  task automatic doReset();
    reset = 1; settle(); advance(); reset = 0;
  endtask

  initial begin
    logic [31:0] expCnt;
`ifdef FWD_PERF_CNT_EN
    expCnt = 32'd3;
`else
    expCnt = 32'd0;
`endif
    quiet(); reset = 1;
    left = '{0, 0}; cnt = '{0, 0};
    @(posedge clk); #1;
    reset = 0;
    settle();
    chk("reset_stall", 32'(stall[0]), 32'd0);
    chk("reset_cnt", stall_cnt[0], 32'd0);
    advance();

    // EX beats MEM on the same register.
    id_valid = 1; id_rs = 3; ex_rw = 3; ex_we = 1; ex_load = 0; ex_result = 32'hAAAA0001;
    mem_rw = 3; mem_we = 1; mem_result = 32'hBBBB0002;
    settle();
    chk("ex_over_mem", busAF[0], 32'hAAAA0001);
    chk("ex_over_mem_stall", 32'(stall[0]), 32'd0);
    advance();

    // r0 never forwarded.
    quiet(); id_valid = 1; id_rt = 0; ex_rw = 0; ex_we = 1; ex_result = 32'h1234; busB = 0;
    settle();
    chk("r0_nofwd", busBF[0], 32'd0);
    advance();

    // One-cycle load-use on LOAD_LAT=3 gives exactly three stall cycles.
    quiet(); doReset();
    id_valid = 1; id_rs = 5; ex_rw = 5; ex_we = 1; ex_load = 1;
    settle(); chk("lu3_c0", 32'(stall[0]), 32'd1); advance();
    quiet();
    settle(); chk("lu3_c1", 32'(stall[0]), 32'd1); advance();
    settle(); chk("lu3_c2", 32'(bubble[0]), 32'd1); advance();
    settle(); chk("lu3_c3", 32'(stall[0]), 32'd0);
    chk("lu3_cnt", stall_cnt[0], expCnt); advance();

    // Reset in the second stall cycle aborts the sequence.
    id_valid = 1; id_rs = 5; ex_rw = 5; ex_we = 1; ex_load = 1;
    settle(); advance();
    quiet(); reset = 1; settle(); advance(); reset = 0;
    settle();
    chk("abort_stall", 32'(stall[0]), 32'd0);
    chk("abort_cnt", stall_cnt[0], 32'd0);
    advance();

    // Both operands on the same load with LOAD_LAT=1: one stall cycle only.
    id_valid = 1; id_rs = 7; id_rt = 7; ex_rw = 7; ex_we = 1; ex_load = 1;
    settle(); chk("dual_c0", 32'(stall[1]), 32'd1); advance();
    ex_load = 0; ex_we = 0;
    settle(); chk("dual_c1", 32'(stall[1]), 32'd0); advance();
    id_valid = 0; ex_load = 1; ex_we = 1;
    settle(); chk("novalid", 32'(stall[1]), 32'd0); advance();

    // Random traffic over a small register window to make matches frequent.
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      id_valid   = ($urandom_range(0, 4) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      busA       = $urandom; busB = $urandom;
      ex_rw      = 5'($urandom_range(0, 3));
      ex_we      = 1'($urandom);
      ex_load    = ($urandom_range(0, 2) == 0);
      ex_result  = $urandom;
      mem_rw     = 5'($urandom_range(0, 3));
      mem_we     = 1'($urandom);
      mem_result = $urandom;
      wb_rw      = 5'($urandom_range(0, 3));
      wb_we      = 1'($urandom);
      wb_result  = $urandom;
      settle();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, operand/result bus width.
REQ-002 SHALL provide parameter REG_AW, default 5, register-specifier width.
REQ-003 SHALL provide parameter LOAD_LAT, default 1, legal 1..4, load-use stall cycles.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-005 SHALL provide id_valid  input  1  decode stage holds a real instruction.
REQ-006 SHALL provide id_rs, id_rt  input  REG_AW each  decode source specifiers.
REQ-007 SHALL provide busA, busB  input  DATA_W each  register-file read data.
REQ-008 SHALL provide ex_rw  input  REG_AW, ex_we  input  1, ex_load  input  1, ex_result  input  DATA_W  EX-stage destination, write enable, load flag, ALU result.
REQ-009 SHALL provide mem_rw  input  REG_AW, mem_we  input  1, mem_result  input  DATA_W  MEM-stage destination, write enable, result (load data when a load).
REQ-010 SHALL provide wb_rw  input  REG_AW, wb_we  input  1, wb_result  input  DATA_W  WB-stage destination, write enable, write data.
REQ-011 SHALL provide busAF, busBF  output  DATA_W each  forwarded operands.
REQ-012 SHALL provide stall  output  1  hold PC and ID register; bubble  output  1  inject NOP into EX.
REQ-013 SHALL provide stall_cnt  output  32  cumulative stall cycles.

Function
REQ-014 Forward select per operand SHALL be combinational, priority EX > MEM > WB > register file.
REQ-015 A stage SHALL match only if its we=1, its rw equals the source specifier, and rw != 0; specifier 0 SHALL always yield the register-file value.
REQ-016 EX SHALL NOT be a forwarding source when ex_load=1; a load match SHALL raise a hazard instead.
REQ-017 hazard = id_valid & ex_we & ex_load & (ex_rw != 0) & (ex_rw == id_rs | ex_rw == id_rt).
REQ-018 FSM states SHALL be IDLE and STALL with a down-counter of width 2.
REQ-019 In IDLE, hazard=1 SHALL assert stall and bubble in the same cycle; if LOAD_LAT>1 the FSM SHALL enter STALL with counter = LOAD_LAT-2 at the next edge, else remain IDLE.
REQ-020 In STALL, stall and bubble SHALL be 1 every cycle; counter SHALL decrement each edge; at counter=0 the FSM SHALL return to IDLE at the next edge.
REQ-021 Hazard detection SHALL be ignored while in STALL (no re-trigger, no extension).
REQ-022 Total stall cycles per load-use event SHALL equal exactly LOAD_LAT.
REQ-023 During stall, busAF/busBF SHALL still reflect REQ-014 rules on current inputs.
REQ-024 Simultaneous match of both operands to the same load SHALL produce one stall sequence, not two.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, counter 0, stall_cnt 0; stall and bubble SHALL be 0 from the following cycle unless hazard is active.
REQ-026 Reset asserted mid-STALL SHALL abort the sequence with no residual stall cycles.

Configuration
REQ-027 Macro FWD_PERF_CNT_EN SHALL control the stall counter.
REQ-028 With FWD_PERF_CNT_EN defined, stall_cnt SHALL increment by 1 on each edge where stall=1 and reset=0, saturating at 0xFFFFFFFF.
REQ-029 Without FWD_PERF_CNT_EN, stall_cnt SHALL be constant 0 and no counter flops SHALL be built.

Verification
REQ-030 id_rs=3, ex_rw=3, ex_we=1, ex_load=0, ex_result=0xAAAA0001, mem_rw=3, mem_we=1 -> busAF=0xAAAA0001, stall=0.
REQ-031 id_rt=0, ex_rw=0, ex_we=1, ex_result=0x1234, busB=0x0 -> busBF=0x0, no forwarding.
REQ-032 LOAD_LAT=3, id_valid=1, id_rs=5, ex_rw=5, ex_we=1, ex_load=1 for one cycle -> stall=bubble=1 for exactly 3 consecutive cycles, then 0; stall_cnt=3 (macro on).
REQ-033 LOAD_LAT=3, hazard triggered, reset=1 in second stall cycle -> stall=0 next cycle, stall_cnt=0.
REQ-034 id_rs=7, id_rt=7, ex_rw=7 load, LOAD_LAT=1 -> single 1-cycle stall; id_valid=0 with same values -> stall=0.
REQ-035 Macro undefined, any hazard sequence -> stall_cnt=0 throughout.
